// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_ctrl
// Purpose  : Sequencer for an MxM output-stationary systolic array. Reads one
//            column of A and one row of B per k-step, skews lanes diagonally,
//            clears the accumulators and flags done when C = A*B is final.
// Options  : SYSTOLIC_CTRL_STALL_EN adds a stall_i input that freezes the
//            FEED/DRAIN pipeline (1-entry park register for in-flight reads).
// Revision : 1.0  initial release
// ============================================================================
module systolic_array_ctrl #(
  parameter  int Q     = 10,
  parameter  int N     = 32,
  parameter  int M     = 3,
  parameter  int K_MAX = 16,
  localparam int KW    = $clog2(K_MAX + 1),
  localparam int AW    = $clog2(K_MAX)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [KW-1:0]   k_len_i,
`ifdef SYSTOLIC_CTRL_STALL_EN
  input  logic            stall_i,
`endif
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            rd_en_o,
  output logic [AW-1:0]   rd_addr_o,
  input  logic [M*N-1:0]  a_rd_data_i,
  input  logic [M*N-1:0]  b_rd_data_i,
  output logic            array_clr_o,
  output logic            array_en_o,
  output logic [M*N-1:0]  x_in_o,
  output logic [M*N-1:0]  y_in_o
);

  // Q is a pass-through format parameter; it only has to fit inside N.
  if (Q >= N) begin : g_q_check
    $error("systolic_array_ctrl: Q must be smaller than N");
  end

  localparam int MAXC = (K_MAX > 2 * M) ? K_MAX : 2 * M;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic            err_q, err_d;
  logic            valid_q;
  logic            w_stall;
  logic            w_adv;
  logic            w_src_vld;
  logic [M*N-1:0]  w_a_src;
  logic [M*N-1:0]  w_b_src;

`ifdef SYSTOLIC_CTRL_STALL_EN
  logic            hold_vld_q;
  logic [M*N-1:0]  hold_a_q;
  logic [M*N-1:0]  hold_b_q;

  assign w_stall   = stall_i && (state_q == S_FEED || state_q == S_DRAIN);
  assign w_src_vld = valid_q | hold_vld_q;
  assign w_a_src   = hold_vld_q ? hold_a_q : a_rd_data_i;
  assign w_b_src   = hold_vld_q ? hold_b_q : b_rd_data_i;

  // Park read data that lands in a stalled cycle until the pipeline resumes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q <= 1'b0;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
    end else if (w_stall) begin
      if (valid_q) begin
        hold_vld_q <= 1'b1;
        hold_a_q   <= a_rd_data_i;
        hold_b_q   <= b_rd_data_i;
      end
    end else begin
      hold_vld_q <= 1'b0;
    end
  end
`else
  assign w_stall   = 1'b0;
  assign w_src_vld = valid_q;
  assign w_a_src   = a_rd_data_i;
  assign w_b_src   = b_rd_data_i;
`endif

  assign w_adv = ~w_stall;

  // State, counters, latched length and the registered error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_len_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_len_q <= k_len_d;
      err_q   <= err_d;
      valid_q <= rd_en_o;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_len_d     = k_len_q;
    err_d       = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    rd_en_o     = 1'b0;
    array_clr_o = 1'b0;
    array_en_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          if (k_len_i != '0 && k_len_i <= KW'(K_MAX)) begin
            k_len_d = k_len_i;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        array_clr_o = 1'b1;
        cnt_d       = '0;
        state_d     = S_FEED;
      end
      S_FEED: begin
        if (!w_stall) begin
          rd_en_o    = 1'b1;
          array_en_o = 1'b1;
          if (cnt_q == CW'(k_len_q) - CW'(1)) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!w_stall) begin
          array_en_o = 1'b1;
          if (cnt_q == CW'(2 * M - 1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr_o = rd_en_o ? cnt_q[AW-1:0] : '0;
  assign err_o     = err_q;

  for (genvar i = 0; i < M; i++) begin : g_lane
    logic [N-1:0] w_x, w_y, w_x_out, w_y_out;

    assign w_x = w_src_vld ? w_a_src[i*N +: N] : '0;
    assign w_y = w_src_vld ? w_b_src[i*N +: N] : '0;

    if (i == 0) begin : g_direct
`ifdef SYSTOLIC_CTRL_STALL_EN
      logic [N-1:0] x_last_q, y_last_q;

      // Remember the last presented word so lane 0 holds during a stall
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_last_q <= '0;
          y_last_q <= '0;
        end else if (w_adv) begin
          x_last_q <= w_x;
          y_last_q <= w_y;
        end
      end
      assign w_x_out = w_adv ? w_x : x_last_q;
      assign w_y_out = w_adv ? w_y : y_last_q;
`else
      assign w_x_out = w_x;
      assign w_y_out = w_y;
`endif
    end else begin : g_delay
      logic [N-1:0] x_sr_q [0:i-1];
      logic [N-1:0] y_sr_q [0:i-1];

      // Delay lane i by i stages to form the diagonal input skew
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < i; s++) begin
            x_sr_q[s] <= '0;
            y_sr_q[s] <= '0;
          end
        end else if (w_adv) begin
          x_sr_q[0] <= w_x;
          y_sr_q[0] <= w_y;
          for (int s = 1; s < i; s++) begin
            x_sr_q[s] <= x_sr_q[s-1];
            y_sr_q[s] <= y_sr_q[s-1];
          end
        end
      end
      assign w_x_out = x_sr_q[i-1];
      assign w_y_out = y_sr_q[i-1];
    end

    assign x_in_o[i*N +: N] = w_x_out;
    assign y_in_o[i*N +: N] = w_y_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_array_ctrl
// Purpose  : Self-checking bench for systolic_array_ctrl. Operand buffers and
//            an output-stationary accumulation model live in the bench; lane
//            timing is predicted from the k-step schedule, acc_sum from A*B.
// Options  : SYSTOLIC_CTRL_STALL_EN enables the stall stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_systolic_array_ctrl;
  localparam int Q = 10, N = 32, M = 3, K_MAX = 16;
  localparam int KW = $clog2(K_MAX + 1), AW = $clog2(K_MAX);
`ifdef SYSTOLIC_CTRL_STALL_EN
  localparam bit HAS_STALL = 1'b1;
`else
  localparam bit HAS_STALL = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic           stall_i = 1'b0;
  logic [KW-1:0]  k_len_i = '0;
  logic           busy_o, done_o, err_o, rd_en_o, array_clr_o, array_en_o;
  logic [AW-1:0]  rd_addr_o;
  logic [M*N-1:0] a_rd_data_i = '0, b_rd_data_i = '0, x_in_o, y_in_o;

  systolic_array_ctrl #(.Q(Q), .N(N), .M(M), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .k_len_i(k_len_i),
`ifdef SYSTOLIC_CTRL_STALL_EN
    .stall_i(stall_i),
`endif
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rd_en_o(rd_en_o),
    .rd_addr_o(rd_addr_o), .a_rd_data_i(a_rd_data_i), .b_rd_data_i(b_rd_data_i),
    .array_clr_o(array_clr_o), .array_en_o(array_en_o),
    .x_in_o(x_in_o), .y_in_o(y_in_o)
  );

  always #5 clk = ~clk;

  longint A_mem [M][K_MAX];
  longint B_mem [K_MAX][M];
  longint acc_obs [M][M];
  int     last_done_c;
  int     n_vec = 0;
  int     n_bad = 0;

  // Operand buffers: one-cycle read latency, garbage when not read
  always @(posedge clk) begin
    for (int i = 0; i < M; i++) begin
      a_rd_data_i[i*N +: N] <= rd_en_o ? N'(A_mem[i][rd_addr_o]) : N'($urandom);
      b_rd_data_i[i*N +: N] <= rd_en_o ? N'(B_mem[rd_addr_o][i]) : N'($urandom);
    end
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint lane(input logic [M*N-1:0] v, input int i);
    logic signed [N-1:0] t;
    t = v[i*N +: N];
    return longint'(t);
  endfunction

  // One matmul job of length k; smask bit c requests stall in cycle c
  task automatic run_mm(input int k, input logic [63:0] smask, input bit rnd, input bit junk);
    longint xh [M][64];
    longint yh [M][64];
    longint xl [M];
    longint yl [M];
    int     p, total;
    bit     fin;
    total = k + 2 * M;
    if (rnd) begin
      for (int i = 0; i < M; i++)
        for (int kk = 0; kk < K_MAX; kk++) begin
          A_mem[i][kk] = longint'($urandom_range(0, 1 << 25)) - (1 << 24);
          B_mem[kk][i] = longint'($urandom_range(0, 1 << 25)) - (1 << 24);
        end
    end
    for (int i = 0; i < M; i++) begin
      xl[i] = 0; yl[i] = 0;
      for (int e = 0; e < 64; e++) begin xh[i][e] = 0; yh[i][e] = 0; end
    end
    p = 0; fin = 1'b0; last_done_c = -1;
    for (int c = 0; c < 300 && !fin; c++) begin
      bit work, isdone, stl, adv;
      @(negedge clk);
      start_i = (c == 0) || (junk && c == 3);
      k_len_i = (c == 0) ? KW'(k) : KW'($urandom_range(0, 31));
      stall_i = (c < 64) ? smask[c] : 1'b0;
      #1;
      work   = (c >= 2) && (p < total);
      isdone = (c >= 2) && (p == total);
      stl    = work && stall_i;
      adv    = work && !stl;
      check_val($sformatf("busy@%0d", c), busy_o, c >= 1);
      check_val($sformatf("clr@%0d", c), array_clr_o, c == 1);
      check_val($sformatf("done@%0d", c), done_o, isdone);
      check_val($sformatf("err@%0d", c), err_o, 0);
      check_val($sformatf("en@%0d", c), array_en_o, adv);
      check_val($sformatf("rd_en@%0d", c), rd_en_o, adv && p < k);
      if (adv && p < k) check_val($sformatf("rd_addr@%0d", c), rd_addr_o, p);
      for (int i = 0; i < M; i++) begin
        longint ex, ey;
        int idx;
        idx = p - 1 - i;
        if (adv) begin
          ex = (idx >= 0 && idx < k) ? A_mem[i][idx] : 0;
          ey = (idx >= 0 && idx < k) ? B_mem[idx][i] : 0;
        end else if (stl) begin
          ex = xl[i]; ey = yl[i];
        end else begin
          ex = 0; ey = 0;
        end
        check_val($sformatf("x%0d@%0d", i, c), lane(x_in_o, i), ex);
        check_val($sformatf("y%0d@%0d", i, c), lane(y_in_o, i), ey);
        xl[i] = ex; yl[i] = ey;
        if (adv) begin
          xh[i][p] = lane(x_in_o, i);
          yh[i][p] = lane(y_in_o, i);
        end
      end
      if (adv) p++;
      if (isdone) begin fin = 1'b1; last_done_c = c; end
    end
    stall_i = 1'b0;
    if (!fin) check_val("done_timeout", 0, 1);
    // Output-stationary PE(i,j) sees lane i delayed by j and lane j delayed by i
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        longint s, g;
        s = 0; g = 0;
        for (int e = 0; e < total; e++)
          if (e >= i && e >= j) s += (xh[i][e-j] * yh[j][e-i]) >>> Q;
        for (int kk = 0; kk < k; kk++) g += (A_mem[i][kk] * B_mem[kk][j]) >>> Q;
        acc_obs[i][j] = s;
        check_val($sformatf("acc%0d%0d", i, j), s, g);
      end
  endtask

  task automatic load_test2();
    for (int i = 0; i < M; i++)
      for (int kk = 0; kk < 3; kk++) begin
        A_mem[i][kk] = longint'(3 * i + kk + 1) << Q;
        B_mem[kk][i] = longint'(9 - 3 * kk - i) << Q;
      end
  endtask

  task automatic check_test2();
    longint tbl [M][M];
    tbl = '{'{30, 24, 18}, '{84, 69, 54}, '{138, 114, 90}};
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        check_val($sformatf("t2_acc%0d%0d", i, j), acc_obs[i][j], tbl[i][j] << Q);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m;
    for (int i = 0; i < M; i++)
      for (int kk = 0; kk < K_MAX; kk++) begin A_mem[i][kk] = 0; B_mem[kk][i] = 0; end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_busy", busy_o, 0);
    check_val("rst_outs", {done_o, err_o, rd_en_o, array_clr_o, array_en_o, rd_addr_o}, 0);
    check_val("rst_x", x_in_o != '0, 0);
    rst_n = 1'b1;

    // Matmul example: M=3, K=3
    load_test2();
    run_mm(3, 64'd0, 1'b0, 1'b0);
    check_val("t2_done_cyc", last_done_c, 11);
    check_test2();

    // Async reset in the middle of FEED
    @(negedge clk); start_i = 1'b1; k_len_i = KW'(8);
    @(negedge clk); start_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("pre_rst_rd_en", rd_en_o, 1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", busy_o, 0);
    check_val("midrst_ctl", {done_o, err_o, rd_en_o, array_clr_o, array_en_o, rd_addr_o}, 0);
    check_val("midrst_xy", (x_in_o != '0) || (y_in_o != '0), 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    // Bad k_len values
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); start_i = 1'b1; k_len_i = (b == 0) ? KW'(0) : KW'(K_MAX + 1);
      @(negedge clk); start_i = 1'b0; #1;
      check_val("bad_err", err_o, 1);
      check_val("bad_busy", busy_o, 0);
      check_val("bad_rd_en", rd_en_o, 0);
      @(negedge clk); #1;
      check_val("bad_err_clr", err_o, 0);
      check_val("bad_busy2", busy_o, 0);
      check_val("bad_rd_en2", rd_en_o, 0);
    end

    // Skew check with K=1
    for (int i = 0; i < M; i++) begin
      A_mem[i][0] = longint'(i + 1) << Q;
      B_mem[0][i] = longint'(i + 4) << Q;
    end
    run_mm(1, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        check_val($sformatf("t4_acc%0d%0d", i, j), acc_obs[i][j], longint'((i + 1) * (j + 4)) << Q);

    // Back-to-back jobs, random operands, boundary lengths, start while busy
    run_mm(K_MAX, 64'd0, 1'b1, 1'b1);
    run_mm(1, 64'd0, 1'b1, 1'b1);
    for (int t = 0; t < 6; t++) begin
      m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      run_mm($urandom_range(1, K_MAX), HAS_STALL ? m : 64'd0, 1'b1, t[0]);
    end

`ifdef SYSTOLIC_CTRL_STALL_EN
    // Matmul example with stall in cycles 4..6
    load_test2();
    run_mm(3, 64'h70, 1'b0, 1'b0);
    check_val("t6_done_cyc", last_done_c, 14);
    check_test2();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
